// File: rtl/inst_fetch_queue_pkg.sv
// Shared core constants and helper types for the instruction fetch queue.
// Holds the default queue depth, instruction/PC widths, the stored entry
// layout and the in-order pop-count rule used by the queue.
package inst_fetch_queue_pkg;

    localparam int IFQ_DEPTH_DEFAULT = 8;
    localparam int INST_W            = 32;
    localparam int PC_W              = 32;

    // One queue entry: PC in the upper half, instruction word in the lower half.
    typedef struct packed {
        logic [PC_W-1:0]   pc;
        logic [INST_W-1:0] inst;
    } ifq_entry_t;

    // Number of instructions decode takes this cycle. Consumption is strictly
    // in order: slot 1 can only go together with slot 0.
    function automatic logic [1:0] ifq_pop_count(input logic [1:0] ready,
                                                 input logic [1:0] valid);
        logic [1:0] n;
        case ({ready[0] & valid[0], ready[1] & valid[1]})
            2'b10:   n = 2'd1;
            2'b11:   n = 2'd2;
            2'b00:   n = 2'd0;
            2'b01:   n = 2'd0;
            default: n = 2'd0;
        endcase
        return n;
    endfunction

    // Number of instructions delivered by one accepted icache pair.
    function automatic logic [1:0] ifq_push_count(input logic accept,
                                                  input logic pair);
        logic [1:0] n;
        case ({accept, pair})
            2'b10:   n = 2'd1;
            2'b11:   n = 2'd2;
            2'b00:   n = 2'd0;
            2'b01:   n = 2'd0;
            default: n = 2'd0;
        endcase
        return n;
    endfunction

endpackage

// File: rtl/inst_fetch_queue.sv
// Instruction fetch queue between the icache and decode.
// Circular register-array buffer of {pc, inst} entries. Accepts up to two
// instructions per cycle from the icache and hands up to two per cycle to
// decode. in_ready depends only on the registered count, so the icache
// handshake has no combinational path from decode. A flush empties the queue
// in one cycle; the synchronous active-low reset overrides everything.
module inst_fetch_queue
    import inst_fetch_queue_pkg::*;
#(
    parameter int DEPTH = IFQ_DEPTH_DEFAULT
) (
    input  logic                 clk,
    input  logic                 rstn,
    input  logic                 in_valid,
    input  logic [63:0]          in_inst,
    input  logic [PC_W-1:0]      in_pc,
    input  logic                 in_flag,
    output logic                 in_ready,
    input  logic                 flush,
    output logic [1:0]           out_valid,
    output logic [INST_W-1:0]    out_inst0,
    output logic [INST_W-1:0]    out_inst1,
    output logic [PC_W-1:0]      out_pc0,
    output logic [PC_W-1:0]      out_pc1,
    input  logic [1:0]           out_ready
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    // Two free slots are needed before a pair can be taken.
    localparam logic [CW-1:0] READY_MAX = CW'(DEPTH - 2);
    localparam logic [CW-1:0] CNT_ONE   = CW'(1);
    localparam logic [CW-1:0] CNT_TWO   = CW'(2);

    ifq_entry_t          entries_q [DEPTH];
    logic [PW-1:0]       head_q;
    logic [PW-1:0]       head_d;
    logic [PW-1:0]       tail_q;
    logic [PW-1:0]       tail_d;
    logic [CW-1:0]       count_q;
    logic [CW-1:0]       count_d;

    logic                push_s;
    logic [1:0]          push_n_s;
    logic [1:0]          pop_n_s;
    logic [1:0]          out_valid_s;
    logic [PW-1:0]       head_p1_s;
    logic [PW-1:0]       tail_p1_s;
    ifq_entry_t          lo_entry_s;
    ifq_entry_t          hi_entry_s;

    // Occupancy-derived status, all from registered state only.
    always_comb begin
        in_ready       = (count_q <= READY_MAX);
        out_valid_s[0] = (count_q >= CNT_ONE);
        out_valid_s[1] = (count_q >= CNT_TWO);
        out_valid      = out_valid_s;
    end

    // Push/pop qualification; pointer arithmetic wraps naturally at DEPTH.
    always_comb begin
        push_s     = in_valid & in_ready & ~flush & rstn;
        push_n_s   = ifq_push_count(push_s, in_flag);
        pop_n_s    = ifq_pop_count(out_ready, out_valid_s);
        head_p1_s  = head_q + PW'(1);
        tail_p1_s  = tail_q + PW'(1);
        lo_entry_s = '{pc: in_pc, inst: in_inst[31:0]};
        hi_entry_s = '{pc: in_pc + 32'd4, inst: in_inst[63:32]};
    end

    // Next-state for pointers and count; flush empties the queue.
    always_comb begin
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;
        if (flush) begin
            head_d  = '0;
            tail_d  = '0;
            count_d = '0;
        end else begin
            head_d  = head_q + PW'(pop_n_s);
            tail_d  = tail_q + PW'(push_n_s);
            count_d = count_q + CW'(push_n_s) - CW'(pop_n_s);
        end
    end

    // Pointer and count registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end

    // Entry storage write; the second word lands at tail+1, wrapping to entry 0.
    always_ff @(posedge clk) begin
        if (push_s) begin
            entries_q[tail_q] <= lo_entry_s;
            if (in_flag) begin
                entries_q[tail_p1_s] <= hi_entry_s;
            end
        end
    end

    // Head and head+1 read ports toward decode.
    always_comb begin
        out_inst0 = entries_q[head_q].inst;
        out_pc0   = entries_q[head_q].pc;
        out_inst1 = entries_q[head_p1_s].inst;
        out_pc1   = entries_q[head_p1_s].pc;
    end

endmodule

// File: tb/tb_inst_fetch_queue.sv
// Self-checking bench for inst_fetch_queue (DEPTH=8): a queue-based reference
// model compared every cycle, plus directed checks with hand-computed values.
module tb_inst_fetch_queue;

    localparam int DEPTH = 8;

    logic        clk;
    logic        rstn;
    logic        in_valid;
    logic [63:0] in_inst;
    logic [31:0] in_pc;
    logic        in_flag;
    logic        in_ready;
    logic        flush;
    logic [1:0]  out_valid;
    logic [31:0] out_inst0;
    logic [31:0] out_inst1;
    logic [31:0] out_pc0;
    logic [31:0] out_pc1;
    logic [1:0]  out_ready;

    int n_total = 0;
    int n_bad   = 0;
    bit chk_en  = 1'b0;

    // Reference model: the queue contents as {pc, inst}, front = slot 0.
    logic [63:0] mq[$];

    inst_fetch_queue #(.DEPTH(DEPTH)) dut (
        .clk       (clk),
        .rstn      (rstn),
        .in_valid  (in_valid),
        .in_inst   (in_inst),
        .in_pc     (in_pc),
        .in_flag   (in_flag),
        .in_ready  (in_ready),
        .flush     (flush),
        .out_valid (out_valid),
        .out_inst0 (out_inst0),
        .out_inst1 (out_inst1),
        .out_pc0   (out_pc0),
        .out_pc1   (out_pc1),
        .out_ready (out_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
        end
    endtask

    // One clock of the model, from the rules: reset/flush empty it; otherwise
    // decode takes in-order instructions from the front and an accepted pair
    // (judged on the occupancy before this edge) appends one or two entries.
    task automatic model_step();
        int sz;
        int npop;
        bit acc;
        sz = mq.size();
        if (!rstn || flush) begin
            mq.delete();
        end else begin
            acc  = in_valid && (sz <= DEPTH - 2);
            npop = 0;
            if (out_ready[0] && sz >= 1) npop = 1;
            if (npop == 1 && out_ready[1] && sz >= 2) npop = 2;
            for (int k = 0; k < npop; k++) void'(mq.pop_front());
            if (acc) begin
                mq.push_back({in_pc, in_inst[31:0]});
                if (in_flag) mq.push_back({in_pc + 32'd4, in_inst[63:32]});
            end
        end
    endtask

    always @(posedge clk) model_step();

    // Compare process: outputs vs model away from the active edge.
    always @(negedge clk) begin
        if (chk_en) begin
            chk("cmp_out_valid", 64'(out_valid), 64'({mq.size() >= 2, mq.size() >= 1}));
            chk("cmp_in_ready", 64'(in_ready), 64'(mq.size() <= DEPTH - 2));
            if (mq.size() >= 1) begin
                chk("cmp_slot0", {out_pc0, out_inst0}, mq[0]);
            end
            if (mq.size() >= 2) begin
                chk("cmp_slot1", {out_pc1, out_inst1}, mq[1]);
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic f, input logic [31:0] pc,
                         input logic [63:0] inst, input logic fl, input logic [1:0] rdy);
        in_valid  = v;
        in_flag   = f;
        in_pc     = pc;
        in_inst   = inst;
        flush     = fl;
        out_ready = rdy;
    endtask

    task automatic idle();
        drive(1'b0, 1'b0, 32'h0000_0000, 64'h0, 1'b0, 2'b00);
    endtask

    initial begin
        rstn = 1'b0;
        idle();
        step();
        chk_en = 1'b1;
        step();
        chk("rst_out_valid", 64'(out_valid), 64'(2'b00));
        chk("rst_in_ready", 64'(in_ready), 64'(1'b1));
        rstn = 1'b1;

        // Single pair into an empty queue appears one cycle later.
        drive(1'b1, 1'b1, 32'h1C00_0000, 64'h02800C0C_0280040C, 1'b0, 2'b00);
        step();
        idle();
        chk("pair_valid", 64'(out_valid), 64'(2'b11));
        chk("pair_pc0", 64'(out_pc0), 64'(32'h1C00_0000));
        chk("pair_inst0", 64'(out_inst0), 64'(32'h0280_040C));
        chk("pair_pc1", 64'(out_pc1), 64'(32'h1C00_0004));
        chk("pair_inst1", 64'(out_inst1), 64'(32'h0280_0C0C));
        drive(1'b0, 1'b0, 32'h0, 64'h0, 1'b0, 2'b11);
        step();
        chk("pair_drained", 64'(out_valid), 64'(2'b00));

        // Fill to 7 with no consumption, then offer a pair while not ready.
        for (int k = 0; k < 3; k++) begin
            drive(1'b1, 1'b1, 32'h1C00_1000 + 32'(k * 8), {32'(k + 100), 32'(k)}, 1'b0, 2'b00);
            step();
        end
        drive(1'b1, 1'b0, 32'h1C00_1018, 64'h0000_0000_AAAA_0006, 1'b0, 2'b00);
        step();
        chk("full_in_ready", 64'(in_ready), 64'(1'b0));
        drive(1'b1, 1'b1, 32'h1C0D_EAD0, 64'hDEAD_BEEF_DEAD_BEEF, 1'b0, 2'b00);
        step();
        chk("full_reject_rdy", 64'(in_ready), 64'(1'b0));
        chk("full_reject_pc0", 64'(out_pc0), 64'(32'h1C00_1000));
        for (int k = 0; k < 4; k++) begin
            drive(1'b0, 1'b0, 32'h0, 64'h0, 1'b0, 2'b11);
            step();
        end
        chk("full_drained", 64'(out_valid), 64'(2'b00));

        // Count 3, simultaneous pair push and double pop keeps count at 3.
        drive(1'b1, 1'b1, 32'h1C00_2000, 64'h1, 1'b0, 2'b00);
        step();
        drive(1'b1, 1'b0, 32'h1C00_2008, 64'h2, 1'b0, 2'b00);
        step();
        drive(1'b1, 1'b1, 32'h1C00_2010, 64'h4444_4444_3333_3333, 1'b0, 2'b11);
        step();
        chk("pp_pc0", 64'(out_pc0), 64'(32'h1C00_2008));
        chk("pp_pc1", 64'(out_pc1), 64'(32'h1C00_2010));
        // Count 4, out_ready=10 pops nothing.
        drive(1'b1, 1'b0, 32'h1C00_2020, 64'h5, 1'b0, 2'b00);
        step();
        drive(1'b0, 1'b0, 32'h0, 64'h0, 1'b0, 2'b10);
        step();
        chk("r10_pc0", 64'(out_pc0), 64'(32'h1C00_2008));
        chk("r10_pc1", 64'(out_pc1), 64'(32'h1C00_2010));
        chk("r10_in_ready", 64'(in_ready), 64'(1'b1));

        // Tail is now 7: a pair straddles entry 7 and entry 0.
        drive(1'b1, 1'b1, 32'h1C00_0100, 64'h2222_2222_1111_1111, 1'b0, 2'b00);
        step();
        for (int k = 0; k < 2; k++) begin
            drive(1'b0, 1'b0, 32'h0, 64'h0, 1'b0, 2'b11);
            step();
        end
        idle();
        chk("wrap_pc0", 64'(out_pc0), 64'(32'h1C00_0100));
        chk("wrap_inst0", 64'(out_inst0), 64'(32'h1111_1111));
        chk("wrap_pc1", 64'(out_pc1), 64'(32'h1C00_0104));
        chk("wrap_inst1", 64'(out_inst1), 64'(32'h2222_2222));
        drive(1'b0, 1'b0, 32'h0, 64'h0, 1'b0, 2'b11);
        step();
        chk("wrap_empty", 64'(out_valid), 64'(2'b00));

        // Count 5, flush wins over push and pop.
        drive(1'b1, 1'b1, 32'h1C00_4000, 64'h7, 1'b0, 2'b00);
        step();
        drive(1'b1, 1'b1, 32'h1C00_4008, 64'h8, 1'b0, 2'b00);
        step();
        drive(1'b1, 1'b0, 32'h1C00_4010, 64'h9, 1'b0, 2'b00);
        step();
        drive(1'b1, 1'b1, 32'h1C00_4020, 64'hA, 1'b1, 2'b11);
        step();
        chk("flush_valid", 64'(out_valid), 64'(2'b00));
        chk("flush_in_ready", 64'(in_ready), 64'(1'b1));
        drive(1'b1, 1'b0, 32'h1C00_3000, 64'h0000_0000_0BAD_F00D, 1'b0, 2'b00);
        step();
        idle();
        chk("postflush_valid", 64'(out_valid), 64'(2'b01));
        chk("postflush_pc0", 64'(out_pc0), 64'(32'h1C00_3000));
        // Hold: nothing changes with no push and no pop.
        for (int k = 0; k < 3; k++) step();
        chk("hold_valid", 64'(out_valid), 64'(2'b01));
        chk("hold_inst0", 64'(out_inst0), 64'(32'h0BAD_F00D));

        // Reset mid-operation discards contents and the in-flight push.
        drive(1'b1, 1'b1, 32'h1C00_5000, 64'hB, 1'b0, 2'b00);
        step();
        rstn = 1'b1;
        drive(1'b1, 1'b1, 32'h1C00_5008, 64'hC, 1'b0, 2'b01);
        rstn = 1'b0;
        step();
        chk("midrst_valid", 64'(out_valid), 64'(2'b00));
        chk("midrst_in_ready", 64'(in_ready), 64'(1'b1));
        rstn = 1'b1;

        // Mixed traffic exercising wrap, backpressure and partial pops.
        for (int i = 0; i < 48; i++) begin
            drive((i % 3) != 2, (i % 2) == 1, 32'h1C01_0000 + 32'(i * 16),
                  {32'(i * 2 + 1), 32'(i * 2)}, (i == 37), 2'((i / 2) % 4));
            step();
        end
        idle();
        step();
        step();

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule

// File: doc/inst_fetch_queue.md
INST_FETCH_QUEUE -- requirements
Module: inst_fetch_queue

Interface
REQ-001 SHALL have parameter DEPTH, default 8, number of instruction entries; power of two, minimum 4.
REQ-002 SHALL have port clk  in  1  clock, all state updates on rising edge.
REQ-003 SHALL have port rstn  in  1  reset, synchronous, active-low.
REQ-004 SHALL have port in_valid  in  1  icache delivers an instruction pair this cycle.
REQ-005 SHALL have port in_inst  in  64  instruction pair; [31:0] at in_pc, [63:32] at in_pc+4.
REQ-006 SHALL have port in_pc  in  32  PC of in_inst[31:0].
REQ-007 SHALL have port in_flag  in  1  0: only [31:0] valid; 1: both words valid.
REQ-008 SHALL have port in_ready  out  1  queue can accept a pair; the icache holds its output while low.
REQ-009 SHALL have port flush  in  1  branch redirect or exception; discard all contents.
REQ-010 SHALL have port out_valid  out  2  bit i: slot i holds a valid instruction.
REQ-011 SHALL have port out_inst0, out_inst1  out  32 each  instructions at queue head and head+1.
REQ-012 SHALL have port out_pc0, out_pc1  out  32 each  PCs of slots 0 and 1.
REQ-013 SHALL have port out_ready  in  2  bit i: decode consumes slot i this cycle.

Function
REQ-014 SHALL store each entry as {pc[31:0], inst[31:0]} in a circular buffer with registered head pointer, tail pointer and count (width log2(DEPTH)+1).
REQ-015 SHALL drive in_ready = (count <= DEPTH-2) from registered count only; no combinational path from out_ready or in_valid.
REQ-016 SHALL accept a push when in_valid & in_ready & !flush: write {in_pc, in_inst[31:0]} at tail; if in_flag, also write {in_pc+4, in_inst[63:32]} at tail+1.
REQ-017 SHALL compute push_n = 0, 1 (flag=0) or 2 (flag=1); tail advances by push_n modulo DEPTH.
REQ-018 SHALL drive out_valid[0] = (count>=1), out_valid[1] = (count>=2); out_inst/out_pc read combinationally from entries head and head+1 (mod DEPTH).
REQ-019 SHALL pop in order: pop_n = 0 if !(out_ready[0]&out_valid[0]); 1 if slot 0 only; 2 if also out_ready[1]&out_valid[1]; out_ready[1] without out_ready[0] pops nothing.
REQ-020 SHALL advance head by pop_n modulo DEPTH.
REQ-021 SHALL update count_next = count + push_n - pop_n when push and pop coincide; entries popped and pushed in the same cycle are independent, because in_ready guarantees two free slots.
REQ-022 SHALL wrap pointers so that a pair straddling entry DEPTH-1 and entry 0 is stored and read correctly.
REQ-023 SHALL give flush priority over push and pop: next cycle head=tail=count=0, out_valid=0, in_ready=1; data in the flush cycle is dropped.
REQ-024 SHALL give push-to-output latency of one cycle: a pair pushed into an empty queue at edge N appears on out_* after edge N.
REQ-025 SHALL hold all state when in_valid=0 and out_ready=0.
REQ-026 SHALL never overflow or underflow; count stays in range 0..DEPTH.

Reset
REQ-027 SHALL, while rstn=0 at a rising edge, set head=0, tail=0, count=0, giving out_valid=2'b00 and in_ready=1.
REQ-028 SHALL make reset override flush, push and pop; entry storage need not be reset.
REQ-029 SHALL, when reset occurs mid-operation, discard all stored instructions, and ignore the in-flight push.

Structure
REQ-030 SHALL place default DEPTH, instruction width (32) and PC width (32) constants in the shared core package.
REQ-031 SHALL be a single module with no sub-modules; the storage is a register array, not a macro RAM.

Verification
REQ-032 SHALL cover: empty, push pc=0x1C000000 inst=0x02800C0C_0280040C flag=1 -> next cycle out_valid=11, out_pc0=0x1C000000, out_inst0=0x0280040C, out_pc1=0x1C000004, out_inst1=0x02800C0C.
REQ-033 SHALL cover: pushes with out_ready=00 until full -> in_ready=0 at count=7 (DEPTH=8); an in_valid pair while in_ready=0 is not stored.
REQ-034 SHALL cover: count=3, push flag=1 with out_ready=11 same cycle -> count=3 next cycle, head advanced 2, tail advanced 2.
REQ-035 SHALL cover: tail=7, push flag=1 pc=0x1C000100 -> entry7 pc=0x1C000100, entry0 pc=0x1C000104, read back in order.
REQ-036 SHALL cover: count=5, flush=1 with in_valid=1 and out_ready=11 -> next cycle count=0, out_valid=00, in_ready=1.
REQ-037 SHALL cover: out_ready=10 with count=4 -> nothing popped, count=4.
